btn_debounce: RTL and testbench
===============================

# btn_debounce

Conditions the raw push-button inputs from the board before they reach the memory-write front end. Each button is synchronized to `clk`, debounced with a per-bit stability counter, and presented as a clean active-low level vector whose encoding matches the `btn[2:0]` input of the write-request decoder. The block also emits a one-cycle press pulse per button for logic that must act once per press rather than for as long as the button is held.

## Interface
Parameters:
- `N_BTN`, 3, number of buttons.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be at least 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`, counter width (derived; not overridden).

Ports:
- `clk`, in, 1, single system clock.
- `reset`, in, 1, synchronous, active-high.
- `btn_raw`, in, `N_BTN`, raw pad inputs, active-low (0 = pressed), asynchronous to `clk`, may bounce.
- `btn_db`, out, `N_BTN`, debounced level, active-low; drives the write decoder's `btn`.
- `press`, out, `N_BTN`, one-cycle active-high pulse on each debounced press (1→0 of `btn_db`).

## Operation
Every bit is processed independently by identical logic:
- **Synchronizer:** a two-flop chain `s1 → s2`. Both flops reset to 1 (released).
- **Stable register** `stable`, which drives `btn_db`. Resets to 1.
- **Counter** `cnt`. Resets to 0.
- **States:**
  - `STABLE`: `s2 == stable`; hold `cnt = 0`.
  - `PENDING`: `s2 != stable`.
- **In `PENDING`:**
  - `cnt` increments each cycle.
  - When the mismatch is observed with `cnt == DEBOUNCE_CYCLES-1`, `stable <= s2`, `cnt <= 0`, and the bit returns to `STABLE`.
  - If `s2 == stable` on any cycle before acceptance (a bounce), `cnt <= 0` and the bit returns to `STABLE`. No partial credit is kept.
- **Press pulse:** `press[i] <= 1` on exactly the edge where `stable[i]` goes 1→0. Otherwise `press[i] <= 0`.
- **Release:** a release (0→1) updates `btn_db` but produces no pulse.
- **Counter width:** the counter saturates logically at `DEBOUNCE_CYCLES-1` because acceptance clears it. It never wraps.
- **Multiple buttons:** simultaneous presses on several bits are accepted and pulsed in the same cycle when their timing coincides. Encoding the result (e.g. `3'b100`) is not this block's concern; the block passes it through.

## Timing
- **Reset values:** `btn_db` = all 1s, `press` = all 0s, all counters 0, all synchronizer flops 1.
- **Reset mid-bounce or mid-count:** on the next edge all state returns to the reset values. An in-progress press is discarded and no pulse is emitted.
- **Latency:** if `btn_raw[i]` changes before edge t0 and stays constant:
  - `s2` holds the new value after edge t0+1.
  - `btn_db[i]` changes after edge t0+1+`DEBOUNCE_CYCLES`.
  - `press[i]` is high for the single cycle following that same edge.
- **Glitch rejection:** any glitch shorter than `DEBOUNCE_CYCLES` cycles at the `s2` output never reaches `btn_db`.
- **Outputs:** all outputs are registered, with no combinational path from `btn_raw`.

## Structure
- **Shared package** `btn_pkg`:
  - `BTN_RELEASED = 1'b1`.
  - `BTN_PRESSED = 1'b0`.
  - The per-bit state enum `db_state_t {STABLE, PENDING}`.
  - Default `DEBOUNCE_CYCLES`.
- **Sub-module** `debounce_bit`: synchronizer, counter and pulse logic for one bit, parameterized by `DEBOUNCE_CYCLES`.
- **Top level:** `btn_debounce` instantiates `N_BTN` copies in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.

1. **Reset:** assert `reset` for 2 cycles with `btn_raw = 3'b000` → `btn_db = 3'b111` and `press = 3'b000` throughout reset and on the first cycle after.
2. **Clean press:** drive `btn_raw = 3'b110` before edge t0 and hold → `btn_db = 3'b110` after edge t0+5, and `press = 3'b001` for exactly one cycle at that point. Releasing to `3'b111` returns `btn_db = 3'b111` 6 edges later with no pulse.
3. **Bounce:** toggle `btn_raw[1]` low 3 cycles / high 1 cycle / low 2 cycles / high → `btn_db` stays `3'b111` and `press` stays 0. Then hold low 10 cycles → a single `press = 3'b010` pulse.
4. **Simultaneous press:** drive `btn_raw = 3'b100` in one cycle → `btn_db = 3'b100` and `press = 3'b011` together after edge t0+5.
5. **Reset mid-count:** press bit 0, assert `reset` at edge t0+3, release `reset` while still pressed → no pulse during reset. A fresh pulse follows 6 cycles after reset deasserts (synchronizer refill plus 4 cycles).
6. **Long hold:** hold a press for 100 cycles → exactly one `press` pulse, and `btn_db` remains stable.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block.
// Buttons are active-low at the pads and stay active-low after debouncing.
package btn_pkg;

  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;

  // 10 ms at a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Per-bit debounce state: STABLE while the synchronized input agrees with
  // the accepted level, PENDING while a disagreement is being timed.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

endpackage : btn_pkg

// File: rtl/debounce_bit.sv
// One-bit button conditioner: two-flop synchronizer, stability counter and
// a one-cycle pulse on each accepted press (released -> pressed).
//
// Handshake: none. The input is a free-running asynchronous level and the
// outputs are registered levels/pulses valid every cycle; there is no
// valid/ready flow control on this block.
module debounce_bit
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o,
  output logic press_o
);

  // Acceptance happens on the cycle the counter already holds this value,
  // so the counter never needs to represent DEBOUNCE_CYCLES itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_t        state;

  // Next-state logic: classify the bit, then count or accept the new level.
  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    state    = (s2_q == stable_q) ? STABLE : PENDING;

    case (state)
      STABLE: begin
        // Any agreement discards partial credit from an earlier bounce.
        cnt_d = '0;
      end
      PENDING: begin
        if (cnt_q == CNT_LAST) begin
          stable_d = s2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // Pulse only on the released -> pressed transition of the clean level.
    press_d = (stable_q == BTN_RELEASED) && (stable_d == BTN_PRESSED);
  end

  // State registers; reset returns everything to the released condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= BTN_RELEASED;
      s2_q     <= BTN_RELEASED;
      stable_q <= BTN_RELEASED;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign db_o    = stable_q;
  assign press_o = press_q;

endmodule : debounce_bit

// File: rtl/btn_debounce.sv
// Debounces N_BTN raw active-low buttons into a clean active-low level
// vector for the write-request decoder, plus per-button press pulses.
// Each bit is independent; simultaneous presses pass through unencoded.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press
);

  // Derived from DEBOUNCE_CYCLES; not meant to be overridden.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // One identical conditioner per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (btn_raw[i]),
      .db_o    (btn_db[i]),
      .press_o (press[i])
    );
  end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with a short debounce window. A windowed reference
// model pushes the expected {btn_db, press} at every clock edge; a monitor
// pops and compares half a cycle later. Directed scenarios add timing and
// pulse-count checks.
module tb_btn_debounce;

  localparam int N = 3;
  localparam int D = 4;
  localparam int W = 2 * N;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_db;
  logic [N-1:0] press;

  int n_vec;
  int n_miss;
  int press_total [N];

  logic [W-1:0] exp_q[$];

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .btn_db  (btn_db),
    .press   (press)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the clean level flips once the synchronized input has
  // disagreed with it for the last D consecutive edges.
  logic [N-1:0] m_s1, m_stable, m_press, m_next;
  logic [N-1:0] m_hist [D];
  logic         all_diff;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1;
      for (int j = 0; j < D; j++) m_hist[j] = '1;
      m_stable = '1;
      m_press  = '0;
    end else begin
      m_next = m_stable;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) m_next[i] = ~m_stable[i];
      end
      m_press  = m_stable & ~m_next;
      m_stable = m_next;
      for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s1;
      m_s1      = btn_raw;
    end
    exp_q.push_back({m_stable, m_press});
  end

  // Monitor: compare DUT against the scoreboard away from the active edge.
  logic [W-1:0] exp_v;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check("sb_db", 32'(btn_db), 32'(exp_v[W-1:N]));
      check("sb_press", 32'(press), 32'(exp_v[N-1:0]));
    end
    for (int i = 0; i < N; i++)
      if (press[i] === 1'b1) press_total[i]++;
  end

  // Driver tasks
  task automatic hold(input logic [N-1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_raw = v;
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(output int s [N]);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) s[i] = press_total[i];
  endtask

  int s0 [N];
  int s1 [N];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < N; i++) press_total[i] = 0;
    reset   = 1'b1;
    btn_raw = 3'b000;

    // 1. Reset with all buttons down at the pads.
    edges(1);
    check("rst_db0", 32'(btn_db), 32'h7);
    check("rst_pr0", 32'(press), 32'h0);
    edges(1);
    check("rst_db1", 32'(btn_db), 32'h7);
    @(negedge clk);
    reset = 1'b0;
    edges(1);
    check("rst_db_after", 32'(btn_db), 32'h7);
    check("rst_pr_after", 32'(press), 32'h0);
    hold(3'b111, 10);

    // 2. Clean press on bit 0, then release.
    @(negedge clk);
    btn_raw = 3'b110;
    edges(5);
    check("clean_db_early", 32'(btn_db), 32'h7);
    edges(1);
    check("clean_db", 32'(btn_db), 32'h6);
    check("clean_pr", 32'(press), 32'h1);
    edges(1);
    check("clean_pr_once", 32'(press), 32'h0);
    hold(3'b110, 3);
    @(negedge clk);
    btn_raw = 3'b111;
    edges(5);
    check("rel_db_early", 32'(btn_db), 32'h6);
    edges(1);
    check("rel_db", 32'(btn_db), 32'h7);
    check("rel_pr", 32'(press), 32'h0);
    hold(3'b111, 4);

    // 3. Bounce on bit 1 is rejected, then a long hold is accepted once.
    snap(s0);
    hold(3'b101, 3);
    hold(3'b111, 1);
    hold(3'b101, 2);
    hold(3'b111, 8);
    snap(s1);
    check("bounce_db", 32'(btn_db), 32'h7);
    check("bounce_pr_cnt", 32'(s1[1] - s0[1]), 32'h0);
    hold(3'b101, 10);
    snap(s0);
    check("bounce_hold_db", 32'(btn_db), 32'h5);
    check("bounce_hold_cnt", 32'(s0[1] - s1[1]), 32'h1);
    hold(3'b111, 10);

    // 4. Simultaneous press of bits 0 and 1.
    @(negedge clk);
    btn_raw = 3'b100;
    edges(6);
    check("simul_db", 32'(btn_db), 32'h4);
    check("simul_pr", 32'(press), 32'h3);
    hold(3'b100, 3);
    hold(3'b111, 10);

    // 5. Reset mid-count, released while still pressed.
    snap(s0);
    @(negedge clk);
    btn_raw = 3'b110;
    edges(2);
    @(negedge clk);
    reset = 1'b1;
    edges(1);
    check("midrst_db", 32'(btn_db), 32'h7);
    hold(3'b110, 2);
    reset = 1'b0;
    edges(5);
    check("midrst_pr_early", 32'(press), 32'h0);
    snap(s1);
    check("midrst_no_pulse", 32'(s1[0] - s0[0]), 32'h0);
    edges(1);
    check("midrst_pr", 32'(press), 32'h1);
    check("midrst_db_after", 32'(btn_db), 32'h6);
    hold(3'b111, 10);

    // 6. Long hold on bit 2, with random dwell before it.
    hold(3'b111, $urandom_range(1, 5));
    snap(s0);
    hold(3'b011, 100);
    snap(s1);
    check("long_cnt", 32'(s1[2] - s0[2]), 32'h1);
    check("long_db", 32'(btn_db), 32'h3);
    hold(3'b111, 10);
    check("final_db", 32'(btn_db), 32'h7);

    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_btn_debounce
